aes_req_sched: RTL and testbench
================================

# aes_req_sched

Parametrised multi-channel request scheduler in front of the iterative AES core. It accepts key/plaintext blocks from NCH independent requesters over valid/ready handshakes and arbitrates round-robin. It drives the core's ld/key/text_in, waits for done, and returns text_out with its channel tag through a small output FIFO, so the core is never stalled by a slow consumer.

## Interface
- NCH, 4, number of requester channels (2..8)
- CW, 2, channel-tag width, equal to clog2(NCH)
- OUT_DEPTH, 2, output FIFO depth (power of 2, at least 2)
- WDOG_CYC, 64, watchdog limit in cycles (used only with AES_SCHED_WDOG_EN)
- clk  in  1  single clock; all logic on its rising edge
- rst  in  1  asynchronous, active-low reset
- req_valid  in  NCH  per-channel request valid
- req_ready  out  NCH  per-channel accept (at most one bit high)
- req_key  in  NCH*128  per-channel key; channel i at [128*i +: 128]
- req_text  in  NCH*128  per-channel plaintext, same packing
- core_ld  out  1  one-cycle load strobe to the core
- core_key  out  128  key to the core, held from LOAD through RUN
- core_text_in  out  128  plaintext to the core, held from LOAD through RUN
- core_done  in  1  core completion strobe
- core_text_out  in  128  core result, valid when core_done is high
- out_valid  out  1  result available
- out_ready  in  1  consumer accept
- out_ch  out  CW  channel tag of the result
- out_text  out  128  ciphertext
- out_err  out  1  result was produced by a watchdog timeout
- blk_cnt  out  16  count of results pushed to the FIFO; wraps

## Operation
- States: IDLE, LOAD, RUN. Reset state is IDLE.
- IDLE: if fifo_cnt < OUT_DEPTH and any req_valid is high, assert req_ready for the granted channel only.
  - Grant is the first valid channel at or after rr_ptr, scanning upward with wrap.
  - On handshake: latch key, text and tag; set rr_ptr = grant+1 mod NCH; go to LOAD.
- LOAD: core_ld=1 for exactly one cycle; go to RUN.
- RUN: wait for core_done. On done, push {tag, core_text_out, err=0}, increment blk_cnt, and go to IDLE.
- core_done is ignored in IDLE and LOAD.
- Output FIFO: out_valid = !empty. Pop on out_valid & out_ready. Push and pop in the same cycle leave the count unchanged.
- Issue requires fifo_cnt < OUT_DEPTH, and only one block is ever in flight, so a push never finds the FIFO full.
- Requester rules: req_key and req_text must be stable only in the handshake cycle. Dropping req_valid without a handshake is legal.
- Reset mid-operation clears everything:
  - state goes to IDLE, core_ld=0, FIFO empty, rr_ptr=0, blk_cnt=0;
  - any in-flight block is discarded;
  - a core_done arriving after reset is ignored.
- Reset values: req_ready=0, core_ld=0, core_key=0, core_text_in=0, out_valid=0, out_ch=0, out_text=0, out_err=0, blk_cnt=0.

## Timing
- Handshake in cycle T, core_ld high in T+1, core_done at T+1+L (L = core latency), result in FIFO at T+2+L.
- If the FIFO was empty, out_valid goes high at T+2+L.
- Next req_ready can be high no earlier than T+2+L.
- Maximum throughput is one block per L+2 cycles.
- req_ready is registered-state driven and combinational from req_valid in IDLE only. No combinational path from out_ready to req_ready.
- out_ch, out_text and out_err are stable while out_valid=1 and out_ready=0.

## Configuration
- AES_SCHED_WDOG_EN defined:
  - a counter runs in RUN, cleared on entry;
  - if it reaches WDOG_CYC without core_done, push {tag, 128'h0, err=1}, increment blk_cnt, and go to IDLE;
  - a late core_done for that block is ignored.
- AES_SCHED_WDOG_EN undefined: no counter, out_err is tied 0, and RUN waits indefinitely.

## Test plan
- Single block, FIPS-197 vector: ch2 sends key 000102…0f and text 00112233…ff; core model L=11. Expect core_ld at T+1, then out_valid at T+13 with out_ch=2, out_text=69c4e0d8…c55a, out_err=0, blk_cnt=1.
- Round-robin: all 4 channels valid continuously, out_ready=1. Grants go 0,1,2,3,0 and out_ch follows the same order; blk_cnt=5 after 5 results.
- Backpressure: out_ready=0, OUT_DEPTH=2, ch0 always valid. Exactly 2 results queue and req_ready stays 0 afterwards. Raising out_ready for 1 cycle gives one pop and exactly one new accept.
- Reset in RUN: rst low 1 cycle, 4 cycles after core_ld; the core still asserts done later. Expect out_valid=0, blk_cnt=0, no push, and rr_ptr=0 (ch0 granted first afterwards).
- Watchdog (macro on, WDOG_CYC=64): the core never asserts done. Expect out_err=1, out_text=0 and the tag pushed 64 cycles after entering RUN. A done injected at cycle 70 is ignored.
- Simultaneous push/pop with FIFO at OUT_DEPTH-1: the count is unchanged and result order is preserved.

Source files
------------

// File: rtl/aes_req_sched.sv
// Round-robin request scheduler for the iterative AES core, with a result FIFO.
// Optional watchdog on core completion is enabled by defining AES_SCHED_WDOG_EN.
module aes_req_sched #(
    parameter int unsigned NCH       = 4,
    parameter int unsigned CW        = 2,
    parameter int unsigned OUT_DEPTH = 2,
    parameter int unsigned WDOG_CYC  = 64
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NCH-1:0]     req_valid,
    output logic [NCH-1:0]     req_ready,
    input  logic [NCH*128-1:0] req_key,
    input  logic [NCH*128-1:0] req_text,
    output logic               core_ld,
    output logic [127:0]       core_key,
    output logic [127:0]       core_text_in,
    input  logic               core_done,
    input  logic [127:0]       core_text_out,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [CW-1:0]      out_ch,
    output logic [127:0]       out_text,
    output logic               out_err,
    output logic [15:0]        blk_cnt
);

    localparam int unsigned PW = $clog2(OUT_DEPTH);
    localparam int unsigned FW = $clog2(OUT_DEPTH + 1);

    typedef enum logic [1:0] {IDLE, LOAD, RUN} state_t;

    state_t         state, state_nxt;
    logic [CW-1:0]  rr_ptr, grant, tag, idx;
    logic           any_valid, can_issue, accept, push, pop;
    logic [127:0]   push_text;
    logic [FW-1:0]  fifo_cnt;
    logic [PW-1:0]  wr_ptr, rd_ptr;
    logic [127:0]   mem_text [OUT_DEPTH];
    logic [CW-1:0]  mem_ch   [OUT_DEPTH];

`ifdef AES_SCHED_WDOG_EN
    localparam int unsigned WW = $clog2(WDOG_CYC + 1);
    logic [WW-1:0]  wdog_cnt;
    logic           push_err;
    logic           mem_err  [OUT_DEPTH];
`endif

    // First valid channel at or after rr_ptr, scanning upward with wrap
    always_comb begin
        grant     = rr_ptr;
        any_valid = 1'b0;
        idx       = '0;
        for (int unsigned i = 0; i < NCH; i++) begin
            idx = CW'((32'(rr_ptr) + i) % NCH);
            if (!any_valid && req_valid[idx]) begin
                any_valid = 1'b1;
                grant     = idx;
            end
        end
    end

    assign can_issue = (fifo_cnt < FW'(OUT_DEPTH));
    assign pop       = out_valid & out_ready;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        req_ready = '0;
        accept    = 1'b0;
        push      = 1'b0;
`ifdef AES_SCHED_WDOG_EN
        push_err  = 1'b0;
`endif
        case (state)
            IDLE: begin
                if (can_issue && any_valid) begin
                    req_ready[grant] = 1'b1;
                    accept           = 1'b1;
                    state_nxt        = LOAD;
                end
            end
            LOAD: state_nxt = RUN;
            RUN: begin
                if (core_done) begin
                    push      = 1'b1;
                    state_nxt = IDLE;
                end
`ifdef AES_SCHED_WDOG_EN
                else if (wdog_cnt == WW'(WDOG_CYC - 1)) begin
                    push      = 1'b1;
                    push_err  = 1'b1;
                    state_nxt = IDLE;
                end
`endif
            end
            default: state_nxt = IDLE;
        endcase
    end

`ifdef AES_SCHED_WDOG_EN
    assign push_text = push_err ? 128'h0 : core_text_out;

    // Cycles spent in RUN for the current block; zero on RUN entry
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)               wdog_cnt <= '0;
        else if (state != RUN)  wdog_cnt <= '0;
        else                    wdog_cnt <= wdog_cnt + WW'(1);
    end
`else
    assign push_text = core_text_out;
`endif

    // Issue-side registers: latched operands, tag, round-robin pointer, block count
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rr_ptr       <= '0;
            tag          <= '0;
            core_key     <= '0;
            core_text_in <= '0;
            core_ld      <= 1'b0;
            blk_cnt      <= '0;
        end else begin
            core_ld <= accept;
            if (accept) begin
                tag          <= grant;
                core_key     <= req_key[32'(grant) * 128 +: 128];
                core_text_in <= req_text[32'(grant) * 128 +: 128];
                rr_ptr       <= CW'((32'(grant) + 1) % NCH);
            end
            if (push) blk_cnt <= blk_cnt + 16'd1;
        end
    end

    // Result FIFO; issue gating guarantees a push never meets a full FIFO
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            fifo_cnt <= '0;
            for (int unsigned i = 0; i < OUT_DEPTH; i++) begin
                mem_text[i] <= '0;
                mem_ch[i]   <= '0;
`ifdef AES_SCHED_WDOG_EN
                mem_err[i]  <= 1'b0;
`endif
            end
        end else begin
            if (push) begin
                mem_text[wr_ptr] <= push_text;
                mem_ch[wr_ptr]   <= tag;
`ifdef AES_SCHED_WDOG_EN
                mem_err[wr_ptr]  <= push_err;
`endif
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) rd_ptr <= rd_ptr + PW'(1);
            case ({push, pop})
                2'b10:   fifo_cnt <= fifo_cnt + FW'(1);
                2'b01:   fifo_cnt <= fifo_cnt - FW'(1);
                default: fifo_cnt <= fifo_cnt;
            endcase
        end
    end

    assign out_valid = (fifo_cnt != '0);
    assign out_ch    = mem_ch[rd_ptr];
    assign out_text  = mem_text[rd_ptr];
`ifdef AES_SCHED_WDOG_EN
    assign out_err   = mem_err[rd_ptr];
`else
    assign out_err   = 1'b0;
`endif

endmodule

// File: tb/tb_aes_req_sched.sv
// Self-checking bench for aes_req_sched with a fixed-latency core model and a result scoreboard.
// Define AES_SCHED_WDOG_EN for both files to exercise the watchdog scenario.
module tb_aes_req_sched;

    localparam int unsigned NCH = 4, CW = 2, OUT_DEPTH = 2, WDOG_CYC = 64, L = 11;
    localparam logic [127:0] FIPS_KEY = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] FIPS_PT  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] FIPS_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

    logic               clk, rst;
    logic [NCH-1:0]     req_valid, req_ready;
    logic [NCH*128-1:0] req_key, req_text;
    logic               core_ld, core_done, out_valid, out_ready, out_err;
    logic [127:0]       core_key, core_text_in, core_text_out, out_text;
    logic [CW-1:0]      out_ch;
    logic [15:0]        blk_cnt;

    typedef struct {
        logic [CW-1:0] ch;
        logic [127:0]  text;
        logic          err;
        int unsigned   cyc;
    } exp_t;

    exp_t        sb[$];
    int unsigned grants[$];
    int          n_chk = 0, n_fail = 0;
    int unsigned cyc_cnt = 0, cur_cyc = 0, hs_ch = 0, hs_cyc = 0;
    bit          hs = 1'b0, popped = 1'b0, rnd_data = 1'b1, wdog_mode = 1'b0, core_mute = 1'b0;
    logic        core_inj;

    aes_req_sched #(.NCH(NCH), .CW(CW), .OUT_DEPTH(OUT_DEPTH), .WDOG_CYC(WDOG_CYC)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
        .req_key(req_key), .req_text(req_text), .core_ld(core_ld), .core_key(core_key),
        .core_text_in(core_text_in), .core_done(core_done), .core_text_out(core_text_out),
        .out_valid(out_valid), .out_ready(out_ready), .out_ch(out_ch), .out_text(out_text),
        .out_err(out_err), .blk_cnt(blk_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    // Stand-in cipher: the FIPS-197 vector maps to its real ciphertext, anything else to a mix
    function automatic logic [127:0] cf(input logic [127:0] k, input logic [127:0] t);
        if (k == FIPS_KEY && t == FIPS_PT) return FIPS_CT;
        return k ^ {t[63:0], t[127:64]} ^ 128'h5a5a_c3c3_0f0f_9696_a5a5_3c3c_f0f0_6969;
    endfunction

    // Core model: done exactly L cycles after ld; text_out is junk except when done is high
    logic [127:0] cm_res = '0;
    int unsigned  cm_cnt = 0;
    logic         cm_done = 1'b0;
    always @(posedge clk) begin
        if (core_ld) begin
            cm_res        <= cf(core_key, core_text_in);
            cm_cnt        <= L - 1;
            cm_done       <= 1'b0;
            core_text_out <= {$urandom, $urandom, $urandom, $urandom};
        end else if (cm_cnt > 0) begin
            cm_cnt <= cm_cnt - 1;
            if (cm_cnt == 1 && !core_mute) begin
                cm_done       <= 1'b1;
                core_text_out <= cm_res;
            end
        end else begin
            cm_done       <= 1'b0;
            core_text_out <= {$urandom, $urandom, $urandom, $urandom};
        end
    end
    assign core_done = cm_done | core_inj;

    task automatic apply_reset();
        rst = 1'b0; req_valid = '0; out_ready = 1'b0; core_inj = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        sb.delete(); grants.delete(); hs = 1'b0;
    endtask

    // One cycle: drive at negedge, observe 1 ns later; handshakes feed the scoreboard
    task automatic drive_cycle(input logic [NCH-1:0] vld, input logic ordy);
        exp_t e;
        @(negedge clk);
        req_valid = vld;
        out_ready = ordy;
        if (rnd_data)
            for (int i = 0; i < NCH; i++) begin
                req_key[128*i +: 128]  = {$urandom, $urandom, $urandom, $urandom};
                req_text[128*i +: 128] = {$urandom, $urandom, $urandom, $urandom};
            end
        #1;
        cur_cyc = cyc_cnt;
        hs = 1'b0;
        for (int i = 0; i < NCH; i++)
            if (req_valid[i] && req_ready[i]) begin
                hs = 1'b1; hs_ch = i; hs_cyc = cur_cyc;
                grants.push_back(i);
                e.ch  = CW'(i);
                e.cyc = cur_cyc;
                if (wdog_mode) begin
                    e.text = '0; e.err = 1'b1;
                end else begin
                    e.text = cf(req_key[128*i +: 128], req_text[128*i +: 128]); e.err = 1'b0;
                end
                sb.push_back(e);
            end
        popped = (out_valid === 1'b1) && out_ready;
    endtask

    task automatic test_reset();
        rst = 1'b0; req_valid = '0; out_ready = 1'b0;
        @(negedge clk);
        @(negedge clk);
        #1;
        n_chk++;
        if ({req_ready, core_ld, out_valid, out_err, out_ch, blk_cnt} !== '0) begin
            n_fail++;
            $display("FAIL reset_ctrl: ready=%b ld=%b ov=%b err=%b ch=%0d blk=%0d, expected all 0",
                     req_ready, core_ld, out_valid, out_err, out_ch, blk_cnt);
        end
        n_chk++;
        if (core_key !== '0) begin n_fail++; $display("FAIL reset_key: got %h, expected 0", core_key); end
        n_chk++;
        if (core_text_in !== '0) begin n_fail++; $display("FAIL reset_text_in: got %h, expected 0", core_text_in); end
        n_chk++;
        if (out_text !== '0) begin n_fail++; $display("FAIL reset_out_text: got %h, expected 0", out_text); end
    endtask

    task automatic test_fips();
        exp_t e;
        int unsigned t0, first_ov;
        bit ld_ok, opnd_ok;
        apply_reset();
        rnd_data = 1'b0;
        req_key = '0; req_text = '0;
        req_key[128*2 +: 128] = FIPS_KEY;
        req_text[128*2 +: 128] = FIPS_PT;
        for (int k = 0; k < 8 && !hs; k++) drive_cycle(4'b0100, 1'b1);
        n_chk++;
        if (!hs || hs_ch != 2) begin
            n_fail++; $display("FAIL fips_grant: handshake=%0b ch=%0d, expected handshake on ch 2", hs, hs_ch);
        end
        t0 = hs_cyc; first_ov = 0; ld_ok = 1'b1; opnd_ok = 1'b1;
        for (int k = 0; k < 20; k++) begin
            drive_cycle('0, 1'b1);
            if (core_ld !== (cur_cyc == t0 + 1)) ld_ok = 1'b0;
            if (cur_cyc == t0 + 1 && (core_key !== FIPS_KEY || core_text_in !== FIPS_PT)) opnd_ok = 1'b0;
            if (out_valid === 1'b1 && first_ov == 0) first_ov = cur_cyc;
            if (popped) begin
                n_chk++;
                if (sb.size() == 0) begin n_fail++; $display("FAIL fips_pop: unexpected result ch=%0d", out_ch); end
                else begin
                    e = sb.pop_front();
                    if (out_ch !== e.ch || out_text !== e.text || out_err !== e.err) begin
                        n_fail++;
                        $display("FAIL fips_result: got ch=%0d text=%h err=%b, expected ch=%0d text=%h err=%b",
                                 out_ch, out_text, out_err, e.ch, e.text, e.err);
                    end
                end
            end
        end
        n_chk++;
        if (!ld_ok) begin n_fail++; $display("FAIL fips_ld: core_ld not a single pulse at cycle %0d", t0 + 1); end
        n_chk++;
        if (!opnd_ok) begin n_fail++; $display("FAIL fips_operands: core_key/text_in differ from the FIPS vector"); end
        n_chk++;
        if (first_ov != t0 + 13) begin
            n_fail++; $display("FAIL fips_latency: out_valid at cycle %0d, expected %0d", first_ov, t0 + 13);
        end
        n_chk++;
        if (blk_cnt !== 16'd1 || sb.size() != 0) begin
            n_fail++; $display("FAIL fips_blk_cnt: got %0d (pending %0d), expected 1 (pending 0)", blk_cnt, sb.size());
        end
        rnd_data = 1'b1;
    endtask

    task automatic test_round_robin();
        exp_t e;
        int npop = 0;
        bit onehot_ok = 1'b1, lat_ok = 1'b1, order_ok = 1'b1;
        apply_reset();
        for (int k = 0; k < 200 && npop < 5; k++) begin
            drive_cycle('1, 1'b1);
            if ($countones(req_ready) > 1) onehot_ok = 1'b0;
            if (popped) begin
                npop++;
                n_chk++;
                if (sb.size() == 0) begin n_fail++; $display("FAIL rr_pop: unexpected result ch=%0d", out_ch); end
                else begin
                    e = sb.pop_front();
                    if (cur_cyc != e.cyc + L + 2) lat_ok = 1'b0;
                    if (out_ch !== e.ch || out_text !== e.text || out_err !== e.err) begin
                        n_fail++;
                        $display("FAIL rr_result: got ch=%0d text=%h err=%b, expected ch=%0d text=%h err=%b",
                                 out_ch, out_text, out_err, e.ch, e.text, e.err);
                    end
                end
            end
        end
        for (int i = 0; i < 5; i++)
            if (i >= grants.size() || grants[i] != i % NCH) order_ok = 1'b0;
        n_chk++;
        if (npop != 5 || !order_ok) begin
            n_fail++; $display("FAIL rr_order: %0d results, grant order %p, expected 5 results in order 0,1,2,3,0", npop, grants);
        end
        n_chk++;
        if (!onehot_ok) begin n_fail++; $display("FAIL rr_onehot: more than one req_ready bit high"); end
        n_chk++;
        if (!lat_ok) begin n_fail++; $display("FAIL rr_latency: a result did not appear %0d cycles after its handshake", L + 2); end
        n_chk++;
        if (blk_cnt !== 16'd5) begin n_fail++; $display("FAIL rr_blk_cnt: got %0d, expected 5", blk_cnt); end
    endtask

    task automatic test_backpressure();
        exp_t e;
        int nacc = 0, npop = 0;
        bit stuck_ok = 1'b1;
        apply_reset();
        for (int k = 0; k < 60; k++) begin
            drive_cycle(4'b0001, 1'b0);
            if (hs) nacc++;
            if (k >= 40 && req_ready !== '0) stuck_ok = 1'b0;
        end
        n_chk++;
        if (nacc != 2 || !stuck_ok || out_valid !== 1'b1) begin
            n_fail++; $display("FAIL bp_full: accepts=%0d stuck=%0b ov=%b, expected 2 accepts then req_ready 0", nacc, stuck_ok, out_valid);
        end
        for (int k = 0; k < 41; k++) begin
            drive_cycle(4'b0001, k == 0);
            if (hs) nacc++;
            if (popped) begin
                npop++;
                n_chk++;
                if (sb.size() == 0) begin n_fail++; $display("FAIL bp_pop: unexpected result ch=%0d", out_ch); end
                else begin
                    e = sb.pop_front();
                    if (out_ch !== e.ch || out_text !== e.text || out_err !== e.err) begin
                        n_fail++;
                        $display("FAIL bp_result: got ch=%0d text=%h err=%b, expected ch=%0d text=%h err=%b",
                                 out_ch, out_text, out_err, e.ch, e.text, e.err);
                    end
                end
            end
        end
        n_chk++;
        if (npop != 1 || nacc != 3) begin
            n_fail++; $display("FAIL bp_one_slot: pops=%0d accepts=%0d, expected 1 pop and 3 accepts", npop, nacc);
        end
        for (int k = 0; k < 10; k++) begin
            drive_cycle('0, 1'b1);
            if (popped) begin
                npop++;
                n_chk++;
                if (sb.size() == 0) begin n_fail++; $display("FAIL bp_drain_pop: unexpected result ch=%0d", out_ch); end
                else begin
                    e = sb.pop_front();
                    if (out_ch !== e.ch || out_text !== e.text || out_err !== e.err) begin
                        n_fail++;
                        $display("FAIL bp_drain: got ch=%0d text=%h, expected ch=%0d text=%h", out_ch, out_text, e.ch, e.text);
                    end
                end
            end
        end
        n_chk++;
        if (npop != 3 || blk_cnt !== 16'd3 || sb.size() != 0) begin
            n_fail++; $display("FAIL bp_total: pops=%0d blk=%0d pending=%0d, expected 3, 3, 0", npop, blk_cnt, sb.size());
        end
    endtask

    task automatic test_push_pop();
        exp_t e;
        int unsigned t2;
        apply_reset();
        for (int k = 0; k < 8 && !hs; k++) drive_cycle(4'b0010, 1'b0);
        for (int k = 0; k < 20 && out_valid !== 1'b1; k++) drive_cycle('0, 1'b0);
        hs = 1'b0;
        for (int k = 0; k < 8 && !hs; k++) drive_cycle(4'b1000, 1'b0);
        t2 = hs_cyc;
        for (int k = 0; k < 20 && cur_cyc < t2 + 11; k++) drive_cycle('0, 1'b0);
        drive_cycle('0, 1'b1);
        n_chk++;
        if (cur_cyc != t2 + 12 || core_done !== 1'b1 || !popped) begin
            n_fail++; $display("FAIL pp_align: cycle=%0d done=%b pop=%0b, expected cycle %0d with done and pop", cur_cyc, core_done, popped, t2 + 12);
        end
        for (int k = 0; k < 2; k++) begin
            if (popped) begin
                n_chk++;
                if (sb.size() == 0) begin n_fail++; $display("FAIL pp_pop: unexpected result ch=%0d", out_ch); end
                else begin
                    e = sb.pop_front();
                    if (out_ch !== e.ch || out_text !== e.text || out_err !== e.err) begin
                        n_fail++;
                        $display("FAIL pp_order: got ch=%0d text=%h, expected ch=%0d text=%h", out_ch, out_text, e.ch, e.text);
                    end
                end
            end
            drive_cycle('0, k == 0 ? 1'b0 : 1'b1);
            if (k == 0) begin
                n_chk++;
                if (out_valid !== 1'b1 || out_ch !== 2'd3) begin
                    n_fail++; $display("FAIL pp_count: ov=%b ch=%0d, expected ov=1 ch=3 after simultaneous push/pop", out_valid, out_ch);
                end
                drive_cycle('0, 1'b1);
            end
        end
        n_chk++;
        if (out_valid !== 1'b0 || sb.size() != 0) begin
            n_fail++; $display("FAIL pp_empty: ov=%b pending=%0d, expected empty", out_valid, sb.size());
        end
    endtask

    task automatic test_reset_in_run();
        int unsigned t0;
        bit quiet_ok = 1'b1;
        apply_reset();
        for (int k = 0; k < 8 && !hs; k++) drive_cycle(4'b0010, 1'b1);
        t0 = hs_cyc;
        for (int k = 0; k < 20 && cur_cyc < t0 + 5; k++) drive_cycle('0, 1'b1);
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        sb.delete(); grants.delete();
        for (int k = 0; k < 12; k++) begin
            drive_cycle('0, 1'b1);
            if (out_valid !== 1'b0 || blk_cnt !== 16'd0 || core_ld !== 1'b0) quiet_ok = 1'b0;
        end
        n_chk++;
        if (!quiet_ok) begin
            n_fail++; $display("FAIL rst_run_quiet: ov=%b blk=%0d ld=%b, expected no result after reset", out_valid, blk_cnt, core_ld);
        end
        hs = 1'b0;
        for (int k = 0; k < 8 && !hs; k++) drive_cycle('1, 1'b1);
        n_chk++;
        if (!hs || hs_ch != 0) begin
            n_fail++; $display("FAIL rst_run_rr: first grant ch=%0d (hs=%0b), expected ch 0", hs_ch, hs);
        end
    endtask

`ifdef AES_SCHED_WDOG_EN
    task automatic test_watchdog();
        exp_t e;
        int unsigned t0, first_ov = 0;
        int npop = 0;
        apply_reset();
        core_mute = 1'b1; wdog_mode = 1'b1;
        for (int k = 0; k < 8 && !hs; k++) drive_cycle(4'b1000, 1'b1);
        t0 = hs_cyc;
        for (int k = 0; k < 100; k++) begin
            drive_cycle('0, 1'b1);
            core_inj = (cur_cyc == t0 + 2 + 70);
            if (out_valid === 1'b1 && first_ov == 0) first_ov = cur_cyc;
            if (popped) begin
                npop++;
                n_chk++;
                if (sb.size() == 0) begin n_fail++; $display("FAIL wdog_pop: unexpected result ch=%0d", out_ch); end
                else begin
                    e = sb.pop_front();
                    if (out_ch !== e.ch || out_text !== e.text || out_err !== e.err) begin
                        n_fail++;
                        $display("FAIL wdog_result: got ch=%0d text=%h err=%b, expected ch=%0d text=%h err=%b",
                                 out_ch, out_text, out_err, e.ch, e.text, e.err);
                    end
                end
            end
        end
        core_inj = 1'b0;
        n_chk++;
        if (first_ov != t0 + 2 + WDOG_CYC) begin
            n_fail++; $display("FAIL wdog_timing: out_valid at %0d, expected %0d", first_ov, t0 + 2 + WDOG_CYC);
        end
        n_chk++;
        if (npop != 1 || blk_cnt !== 16'd1) begin
            n_fail++; $display("FAIL wdog_late_done: pops=%0d blk=%0d, expected 1 and 1", npop, blk_cnt);
        end
        core_mute = 1'b0; wdog_mode = 1'b0;
    endtask
`endif

    initial begin
        rst = 1'b0; req_valid = '0; out_ready = 1'b0; core_inj = 1'b0;
        req_key = '0; req_text = '0; core_text_out = '0;
        test_reset();
        test_fips();
        test_round_robin();
        test_backpressure();
        test_push_pop();
        test_reset_in_run();
`ifdef AES_SCHED_WDOG_EN
        test_watchdog();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
